// File: rtl/multi_unit_combiner.sv
// Merges the pad outputs of NUM_UNITS compute units into one registered pad set.
// Modes: XOR, OR, round-robin and output-enable priority, plus a sticky conflict flag.
module multi_unit_combiner #(
    parameter int NUM_UNITS = 4,
    parameter int DATA_W    = 8,
    parameter int DWELL     = 4,
    localparam int IDX_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic [1:0]                  mode,
    input  logic                        clear_conflict,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_uo,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_uio_out,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_uio_oe,
    output logic [DATA_W-1:0]           uo_out,
    output logic [DATA_W-1:0]           uio_out,
    output logic [DATA_W-1:0]           uio_oe,
    output logic [IDX_W-1:0]            rr_idx,
    output logic                        conflict
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0]  dwell_cnt;
    logic [DATA_W-1:0] xor_uo, or_uo, or_mio, or_oe;
    logic [DATA_W-1:0] seen, overlap;
    logic [DATA_W-1:0] rr_uo, rr_mio, rr_oe;
    logic [DATA_W-1:0] pri_uo, pri_mio, pri_oe;
    logic [DATA_W-1:0] nxt_uo, nxt_mio, nxt_oe;
    logic              found;

    always_comb begin
        xor_uo  = '0;
        or_uo   = '0;
        or_mio  = '0;
        or_oe   = '0;
        seen    = '0;
        overlap = '0;
        rr_uo   = '0;
        rr_mio  = '0;
        rr_oe   = '0;
        pri_uo  = unit_uo[DATA_W-1:0];
        pri_mio = '0;
        pri_oe  = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            xor_uo  = xor_uo ^ unit_uo[k*DATA_W +: DATA_W];
            or_uo   = or_uo | unit_uo[k*DATA_W +: DATA_W];
            or_mio  = or_mio | (unit_uio_out[k*DATA_W +: DATA_W]
                               & unit_uio_oe[k*DATA_W +: DATA_W]);
            or_oe   = or_oe | unit_uio_oe[k*DATA_W +: DATA_W];
            // A bit already claimed by a lower unit marks contention
            overlap = overlap | (seen & unit_uio_oe[k*DATA_W +: DATA_W]);
            seen    = seen | unit_uio_oe[k*DATA_W +: DATA_W];
            if (rr_idx == IDX_W'(k)) begin
                rr_uo  = unit_uo[k*DATA_W +: DATA_W];
                rr_mio = unit_uio_out[k*DATA_W +: DATA_W]
                       & unit_uio_oe[k*DATA_W +: DATA_W];
                rr_oe  = unit_uio_oe[k*DATA_W +: DATA_W];
            end
            if (!found && (|unit_uio_oe[k*DATA_W +: DATA_W])) begin
                found   = 1'b1;
                pri_uo  = unit_uo[k*DATA_W +: DATA_W];
                pri_mio = unit_uio_out[k*DATA_W +: DATA_W]
                        & unit_uio_oe[k*DATA_W +: DATA_W];
                pri_oe  = unit_uio_oe[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        nxt_uo  = xor_uo;
        nxt_mio = or_mio;
        nxt_oe  = or_oe;
        unique case (mode)
            2'd0: nxt_uo = xor_uo;
            2'd1: nxt_uo = or_uo;
            2'd2: begin
                nxt_uo  = rr_uo;
                nxt_mio = rr_mio;
                nxt_oe  = rr_oe;
            end
            2'd3: begin
                nxt_uo  = pri_uo;
                nxt_mio = pri_mio;
                nxt_oe  = pri_oe;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uo_out    <= '0;
            uio_out   <= '0;
            uio_oe    <= '0;
            rr_idx    <= '0;
            dwell_cnt <= '0;
            conflict  <= 1'b0;
        end else if (ena) begin
            uo_out   <= nxt_uo;
            uio_out  <= nxt_mio;
            uio_oe   <= nxt_oe;
            conflict <= (|overlap) | (conflict & ~clear_conflict);
            if (mode == 2'd2) begin
                if (dwell_cnt == LAST_CNT) begin
                    dwell_cnt <= '0;
                    rr_idx    <= (rr_idx == LAST_IDX) ? '0 : rr_idx + 1'b1;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
            end else begin
                rr_idx    <= '0;
                dwell_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/multi_unit_combiner.md
Name: multi_unit_combiner

Overview:
Parametrised successor to the two-unit chip-top output merge. Combines the pad-facing outputs of NUM_UNITS compute units (uo, uio_out, uio_oe) into one pad set. Four runtime-selectable merge modes: XOR, OR, time-multiplexed round-robin, and output-enable priority. All outputs are registered, and a sticky flag reports output-enable contention. Sits between the compute-unit array and the top-level pads.

Parameters:
NUM_UNITS, 4, number of compute units merged (>=1)
DATA_W, 8, width of each pad bus
DWELL, 4, cycles each unit is held in round-robin mode (>=1)
(derived localparam IDX_W = max(1, clog2(NUM_UNITS)))

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
ena  input  1  global enable; 0 freezes all registers
mode  input  2  0=XOR, 1=OR, 2=ROUND_ROBIN, 3=PRIORITY
clear_conflict  input  1  clears sticky conflict flag
unit_uo  input  NUM_UNITS*DATA_W  unit k at [k*DATA_W +: DATA_W]
unit_uio_out  input  NUM_UNITS*DATA_W  per-unit bidir output data, same packing
unit_uio_oe  input  NUM_UNITS*DATA_W  per-unit bidir enables, same packing
uo_out  output  DATA_W  merged dedicated output (registered)
uio_out  output  DATA_W  merged bidir output data (registered)
uio_oe  output  DATA_W  merged bidir enables (registered)
rr_idx  output  IDX_W  unit currently selected in ROUND_ROBIN; 0 in other modes
conflict  output  1  sticky contention flag (registered)

Behaviour:
- Reset: on a clk edge with rst=1, uo_out, uio_out, uio_oe, rr_idx, the internal dwell counter and conflict all go to 0. rst has priority over ena and over every other input.
- ena=0 (rst=0): no register changes. Outputs, rr_idx, the dwell counter and conflict hold.
- Latency: exactly 1 cycle from inputs/mode to outputs. No combinational path from input to output.
- Masking: in every mode, unit k's uio_out contributes only on bits where its uio_oe is 1 (masked = uio_out & uio_oe).
- mode 0 XOR: uo_out <= XOR of all unit_uo; uio_out <= OR of masked uio_out; uio_oe <= OR of all uio_oe.
- mode 1 OR: same as mode 0, except uo_out <= OR of all unit_uo.
- mode 2 ROUND_ROBIN:
  - Outputs take only unit[rr_idx]: its uo, its masked uio_out, and its uio_oe. The current (pre-update) rr_idx is used.
  - Dwell counter runs 0..DWELL-1. When it equals DWELL-1, it resets to 0 and rr_idx increments, wrapping NUM_UNITS-1 -> 0. Otherwise the counter increments.
  - DWELL=1 rotates every cycle. NUM_UNITS=1 keeps rr_idx at 0.
- Outside mode 2: rr_idx and the dwell counter are forced to 0, so entering mode 2 always starts at unit 0, dwell 0. A mid-sequence mode change abandons the rotation.
- mode 3 PRIORITY: select the lowest-index unit with any uio_oe bit set, and output its uo, masked uio_out and uio_oe. If no unit enables any bit: uo_out <= unit 0 uo, uio_out <= 0, uio_oe <= 0.
- Conflict detection (all modes, ena=1):
  - Set when any bit position has uio_oe=1 from two or more units in the same cycle.
  - Registered; visible the cycle after the overlap.
  - Sticky until clear_conflict=1 or rst.
  - If clear_conflict=1 and a new overlap occur in the same cycle, set wins (conflict stays 1).
- Unused mode encodings: none; all 4 are defined.
- Width rules: all reductions are bitwise over DATA_W with no carries. Index arithmetic wraps modulo NUM_UNITS, not modulo 2^IDX_W.

Test Plan:
(NUM_UNITS=4, DATA_W=8, DWELL=2 unless noted)
1. Reset: rst=1 for 2 cycles with all inputs 0xFF, mode=2 -> uo_out=uio_out=uio_oe=0x00, rr_idx=0, conflict=0. Release -> first output appears 1 cycle later.
2. XOR: unit_uo=0x0F,0xF0,0x33,0x00; uio_oe=0x01,0x02,0x04,0x08; all uio_out=0xFF -> next cycle uo_out=0xCC, uio_out=0x0F, uio_oe=0x0F, conflict=0. Switch to mode 1 -> uo_out=0xFF.
3. Round-robin: mode=2, unit_uo=0x10,0x11,0x12,0x13 held -> uo_out per cycle 0x10,0x10,0x11,0x11,0x12,0x12,0x13,0x13,0x10; rr_idx wraps 3->0. Switch to mode 0 and back -> restarts at 0x10.
4. Priority: uio_oe=0x00,0x00,0x80,0x01, unit_uo[2]=0x5A, unit_uio_out[2]=0xFF -> uo_out=0x5A, uio_out=0x80, uio_oe=0x80. All oe=0 with unit_uo[0]=0x77 -> uo_out=0x77, uio_oe=0x00.
5. Conflict:
   - uio_oe unit0=0x03, unit1=0x02 -> conflict=1 next cycle; stays 1 after overlap removed.
   - clear_conflict=1 with a fresh overlap in the same cycle -> stays 1.
   - clear_conflict alone -> 0.
6. Freeze/reset mid-operation: in mode 2 at rr_idx=2, ena=0 for 3 cycles -> outputs and rr_idx unchanged; ena=1 resumes dwell where it stopped. rst=1 at rr_idx=3 -> rr_idx=0 and outputs 0 next cycle.
